// File: rtl/spec_rob_pkg.sv
// spec_rob shared definitions.
// Instruction-type encodings and width helpers.
package spec_rob_pkg;

  typedef enum logic [1:0] {
    TY_ALU    = 2'd0,
    TY_LOAD   = 2'd1,
    TY_STORE  = 2'd2,
    TY_BRANCH = 2'd3
  } rob_type_e;

  localparam int DEPTH_MIN = 4;
  localparam int DEPTH_MAX = 256;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/spec_rob_if.sv
// spec_rob port bundle: dispatch, result buses,
// operand lookup and commit, seen from the buffer (slave).
interface spec_rob_if #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int RD_W   = 5,
  parameter int TYPE_W = 2
);
  import spec_rob_pkg::*;
  localparam int AW = clog2(DEPTH);

  logic              flush;
  logic              alloc_req;
  logic [RD_W-1:0]   alloc_rd;
  logic [PC_W-1:0]   alloc_pc;
  logic [TYPE_W-1:0] alloc_type;
  logic              alloc_gnt;
  logic [AW-1:0]     alloc_tag;
  logic              upd0_en;
  logic [AW-1:0]     upd0_tag;
  logic [DATA_W-1:0] upd0_data;
  logic              upd1_en;
  logic [AW-1:0]     upd1_tag;
  logic [DATA_W-1:0] upd1_data;
  logic [AW-1:0]     rd0_tag;
  logic [DATA_W-1:0] rd0_data;
  logic              rd0_ready;
  logic [AW-1:0]     rd1_tag;
  logic [DATA_W-1:0] rd1_data;
  logic              rd1_ready;
  logic              commit_valid;
  logic [RD_W-1:0]   commit_rd;
  logic [PC_W-1:0]   commit_pc;
  logic [TYPE_W-1:0] commit_type;
  logic [DATA_W-1:0] commit_data;
  logic              commit_ack;
  logic              full;
  logic              empty;
  logic [AW:0]       count;

  modport master (
    output flush, alloc_req, alloc_rd, alloc_pc, alloc_type,
    output upd0_en, upd0_tag, upd0_data,
    output upd1_en, upd1_tag, upd1_data,
    output rd0_tag, rd1_tag, commit_ack,
    input  alloc_gnt, alloc_tag,
    input  rd0_data, rd0_ready, rd1_data, rd1_ready,
    input  commit_valid, commit_rd, commit_pc,
    input  commit_type, commit_data,
    input  full, empty, count
  );

  modport slave (
    input  flush, alloc_req, alloc_rd, alloc_pc, alloc_type,
    input  upd0_en, upd0_tag, upd0_data,
    input  upd1_en, upd1_tag, upd1_data,
    input  rd0_tag, rd1_tag, commit_ack,
    output alloc_gnt, alloc_tag,
    output rd0_data, rd0_ready, rd1_data, rd1_ready,
    output commit_valid, commit_rd, commit_pc,
    output commit_type, commit_data,
    output full, empty, count
  );

endinterface

// File: rtl/spec_rob_rdport.sv
// Tagged operand read port with same-cycle
// forwarding from both result buses (port 1 first).
module spec_rob_rdport
  import spec_rob_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 32,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic [AW-1:0]                  tag_i,
  input  logic [DEPTH-1:0]               vld_i,
  input  logic [DEPTH-1:0]               sv_i,
  input  logic [DEPTH-1:0][DATA_W-1:0]   data_i,
  input  logic                           upd0_en_i,
  input  logic [AW-1:0]                  upd0_tag_i,
  input  logic [DATA_W-1:0]              upd0_data_i,
  input  logic                           upd1_en_i,
  input  logic [AW-1:0]                  upd1_tag_i,
  input  logic [DATA_W-1:0]              upd1_data_i,
  output logic [DATA_W-1:0]              data_o,
  output logic                           ready_o
);

  logic hit0, hit1;

  assign hit0 = upd0_en_i && (upd0_tag_i == tag_i)
             && vld_i[tag_i];
  assign hit1 = upd1_en_i && (upd1_tag_i == tag_i)
             && vld_i[tag_i];

  always_comb begin
    data_o  = data_i[tag_i];
    ready_o = vld_i[tag_i] & sv_i[tag_i];
    priority case (1'b1)
      hit1: begin
        data_o  = upd1_data_i;
        ready_o = 1'b1;
      end
      hit0: begin
        data_o  = upd0_data_i;
        ready_o = 1'b1;
      end
      default: begin
        data_o  = data_i[tag_i];
        ready_o = vld_i[tag_i] & sv_i[tag_i];
      end
    endcase
  end

endmodule

// File: rtl/spec_rob.sv
// Speculative register buffer: circular reorder buffer with
// in-order alloc/commit, two update ports, two forwarded reads.
module spec_rob
  import spec_rob_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int RD_W   = 5,
  parameter int TYPE_W = 2
) (
  input  logic      clock,
  input  logic      reset,
  spec_rob_if.slave bus
);

  localparam int AW = clog2(DEPTH);

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [PC_W-1:0]   pc;
    logic [TYPE_W-1:0] ty;
    logic [DATA_W-1:0] data;
    logic              sv;
    logic              vld;
  } ent_t;

  ent_t          ent_q [DEPTH];
  ent_t          ent_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full, gnt, pop, cvld;

  logic [DEPTH-1:0]             vld_v, sv_v;
  logic [DEPTH-1:0][DATA_W-1:0] data_v;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      vld_v[i]  = ent_q[i].vld;
      sv_v[i]   = ent_q[i].sv;
      data_v[i] = ent_q[i].data;
    end
  end

  assign full = (cnt_q == (AW+1)'(DEPTH));
  assign cvld = ent_q[head_q].vld & ent_q[head_q].sv;
  // Grant is gated by reset so dispatch sees no grant while held.
  assign gnt  = bus.alloc_req & ~full & ~bus.flush & reset;
  assign pop  = cvld & bus.commit_ack;

  always_comb begin
    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i].vld = 1'b0;
        ent_d[i].sv  = 1'b0;
      end
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (bus.upd0_en && ent_q[bus.upd0_tag].vld) begin
        ent_d[bus.upd0_tag].data = bus.upd0_data;
        ent_d[bus.upd0_tag].sv   = 1'b1;
      end
      if (bus.upd1_en && ent_q[bus.upd1_tag].vld) begin
        ent_d[bus.upd1_tag].data = bus.upd1_data;
        ent_d[bus.upd1_tag].sv   = 1'b1;
      end
      if (pop) begin
        ent_d[head_q].vld = 1'b0;
        head_d = head_q + AW'(1);
      end
      if (gnt) begin
        ent_d[tail_q] = '{rd:   bus.alloc_rd,
                          pc:   bus.alloc_pc,
                          ty:   bus.alloc_type,
                          data: '0,
                          sv:   1'b0,
                          vld:  1'b1};
        tail_d = tail_q + AW'(1);
      end
      cnt_d = cnt_q + {{AW{1'b0}}, gnt}
                    - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent_q  <= ent_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.alloc_gnt    = gnt;
  assign bus.alloc_tag    = tail_q;
  assign bus.commit_valid = cvld;
  assign bus.commit_rd    = ent_q[head_q].rd;
  assign bus.commit_pc    = ent_q[head_q].pc;
  assign bus.commit_type  = ent_q[head_q].ty;
  assign bus.commit_data  = ent_q[head_q].data;
  assign bus.full         = full;
  assign bus.empty        = (cnt_q == '0);
  assign bus.count        = cnt_q;

  spec_rob_rdport #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) u_rd0 (
    .tag_i       (bus.rd0_tag),
    .vld_i       (vld_v),
    .sv_i        (sv_v),
    .data_i      (data_v),
    .upd0_en_i   (bus.upd0_en),
    .upd0_tag_i  (bus.upd0_tag),
    .upd0_data_i (bus.upd0_data),
    .upd1_en_i   (bus.upd1_en),
    .upd1_tag_i  (bus.upd1_tag),
    .upd1_data_i (bus.upd1_data),
    .data_o      (bus.rd0_data),
    .ready_o     (bus.rd0_ready)
  );

  spec_rob_rdport #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) u_rd1 (
    .tag_i       (bus.rd1_tag),
    .vld_i       (vld_v),
    .sv_i        (sv_v),
    .data_i      (data_v),
    .upd0_en_i   (bus.upd0_en),
    .upd0_tag_i  (bus.upd0_tag),
    .upd0_data_i (bus.upd0_data),
    .upd1_en_i   (bus.upd1_en),
    .upd1_tag_i  (bus.upd1_tag),
    .upd1_data_i (bus.upd1_data),
    .data_o      (bus.rd1_data),
    .ready_o     (bus.rd1_ready)
  );

endmodule

// File: tb/tb_spec_rob.sv
// Directed bench for spec_rob at DEPTH=4.
// Hand-computed expectations for alloc, forward, commit, wrap, flush.
module tb_spec_rob;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  spec_rob_if #(.DEPTH(4)) bus ();

  spec_rob #(.DEPTH(4)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle();
    bus.flush      = 1'b0;
    bus.alloc_req  = 1'b0;
    bus.alloc_rd   = '0;
    bus.alloc_pc   = '0;
    bus.alloc_type = '0;
    bus.upd0_en    = 1'b0;
    bus.upd0_tag   = '0;
    bus.upd0_data  = '0;
    bus.upd1_en    = 1'b0;
    bus.upd1_tag   = '0;
    bus.upd1_data  = '0;
    bus.rd0_tag    = '0;
    bus.rd1_tag    = '0;
    bus.commit_ack = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input int rd, input int pc, input int ty,
                       input int exp_tag);
    bus.alloc_req  = 1'b1;
    bus.alloc_rd   = 5'(rd);
    bus.alloc_pc   = 32'(pc);
    bus.alloc_type = 2'(ty);
    #1;
    chk("alloc_gnt", bus.alloc_gnt, 1);
    chk("alloc_tag", bus.alloc_tag, exp_tag);
    tick();
    idle();
  endtask

  logic [31:0] exp_d [3];
  int          exp_r [3];

  initial begin
    rst_n = 1'b0;
    idle();
    bus.alloc_req = 1'b1;
    #2;
    chk("rst_gnt", bus.alloc_gnt, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_count", bus.count, 0);
    chk("rst_cvalid", bus.commit_valid, 0);
    chk("rst_tag", bus.alloc_tag, 0);
    chk("rst_rdy0", bus.rd0_ready, 0);
    chk("rst_rdata0", bus.rd0_data, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    idle();
    #1;
    chk("idle_empty", bus.empty, 1);
    chk("idle_count", bus.count, 0);

    for (int i = 0; i < 4; i++) alloc(i + 1, 'h100 + 4 * i, i, i);
    #1;
    chk("fill_full", bus.full, 1);
    chk("fill_count", bus.count, 4);
    chk("fill_empty", bus.empty, 0);
    bus.alloc_req = 1'b1;
    #1;
    chk("full_gnt", bus.alloc_gnt, 0);
    tick();
    idle();
    bus.upd0_en   = 1'b1;
    bus.upd0_tag  = 2'd0;
    bus.upd0_data = 32'hA0;
    tick();
    idle();
    #1;
    chk("c0_valid", bus.commit_valid, 1);
    chk("c0_rd", bus.commit_rd, 1);
    chk("c0_pc", bus.commit_pc, 'h100);
    chk("c0_type", bus.commit_type, 0);
    chk("c0_data", bus.commit_data, 'hA0);
    bus.commit_ack = 1'b1;
    bus.alloc_req  = 1'b1;
    #1;
    chk("full_pop_gnt", bus.alloc_gnt, 0);
    tick();
    idle();
    #1;
    chk("pop_count", bus.count, 3);
    chk("pop_full", bus.full, 0);
    chk("pop_cvalid", bus.commit_valid, 0);
    chk("pop_tail", bus.alloc_tag, 0);

    bus.upd0_en   = 1'b1;
    bus.upd0_tag  = 2'd2;
    bus.upd0_data = 32'hDEADBEEF;
    bus.rd0_tag   = 2'd2;
    bus.rd1_tag   = 2'd3;
    #1;
    chk("fwd_rdy0", bus.rd0_ready, 1);
    chk("fwd_data0", bus.rd0_data, 'hDEADBEEF);
    chk("fwd_rdy1", bus.rd1_ready, 0);
    tick();
    idle();
    bus.rd0_tag = 2'd2;
    #1;
    chk("arr_rdy0", bus.rd0_ready, 1);
    chk("arr_data0", bus.rd0_data, 'hDEADBEEF);
    bus.upd0_en = 1'b1; bus.upd0_tag = 2'd2; bus.upd0_data = 32'h1;
    bus.upd1_en = 1'b1; bus.upd1_tag = 2'd2; bus.upd1_data = 32'h2;
    #1;
    chk("both_fwd", bus.rd0_data, 2);
    tick();
    idle();
    bus.rd0_tag = 2'd2;
    #1;
    chk("both_store", bus.rd0_data, 2);
    bus.upd0_en = 1'b1; bus.upd0_tag = 2'd0; bus.upd0_data = 32'h55;
    bus.rd1_tag = 2'd0;
    #1;
    chk("inv_rdy1", bus.rd1_ready, 0);
    chk("inv_data1", bus.rd1_data, 'hA0);
    tick();
    idle();
    bus.rd1_tag = 2'd0;
    #1;
    chk("inv_keep", bus.rd1_data, 'hA0);

    bus.upd1_en = 1'b1; bus.upd1_tag = 2'd3; bus.upd1_data = 32'h33;
    tick();
    idle();
    #1;
    chk("ooo_wait", bus.commit_valid, 0);
    bus.upd0_en = 1'b1; bus.upd0_tag = 2'd1; bus.upd0_data = 32'h11;
    bus.commit_ack = 1'b1;
    #1;
    chk("no_cfwd", bus.commit_valid, 0);
    tick();
    idle();
    #1;
    chk("ooo_ready", bus.commit_valid, 1);
    tick();
    #1;
    chk("stall_data", bus.commit_data, 'h11);
    chk("stall_count", bus.count, 3);
    exp_d[0] = 32'h11; exp_d[1] = 32'h2; exp_d[2] = 32'h33;
    exp_r[0] = 2;      exp_r[1] = 3;     exp_r[2] = 4;
    for (int k = 0; k < 3; k++) begin
      bus.commit_ack = 1'b1;
      #1;
      chk("inord_valid", bus.commit_valid, 1);
      chk("inord_data", bus.commit_data, exp_d[k]);
      chk("inord_rd", bus.commit_rd, exp_r[k]);
      tick();
      idle();
    end
    #1;
    chk("drain_empty", bus.empty, 1);
    chk("drain_cvalid", bus.commit_valid, 0);

    for (int k = 0; k < 10; k++) begin
      alloc(k, 4 * k, 0, k % 4);
      bus.upd0_en   = 1'b1;
      bus.upd0_tag  = 2'(k % 4);
      bus.upd0_data = 32'h1000 + k;
      tick();
      idle();
      #1;
      chk("wrap_count", bus.count, 1);
      bus.commit_ack = 1'b1;
      #1;
      chk("wrap_data", bus.commit_data, 'h1000 + k);
      tick();
      idle();
    end

    alloc(7, 'h200, 1, 2);
    alloc(8, 'h204, 2, 3);
    alloc(9, 'h208, 3, 0);
    bus.upd0_en = 1'b1; bus.upd0_tag = 2'd2; bus.upd0_data = 32'h77;
    tick();
    idle();
    #1;
    chk("pre_fl_cv", bus.commit_valid, 1);
    chk("pre_fl_cnt", bus.count, 3);
    bus.flush      = 1'b1;
    bus.alloc_req  = 1'b1;
    bus.upd0_en    = 1'b1;
    bus.upd0_tag   = 2'd3;
    bus.upd0_data  = 32'h99;
    bus.commit_ack = 1'b1;
    #1;
    chk("fl_gnt", bus.alloc_gnt, 0);
    tick();
    idle();
    bus.rd0_tag = 2'd3;
    #1;
    chk("fl_count", bus.count, 0);
    chk("fl_empty", bus.empty, 1);
    chk("fl_cvalid", bus.commit_valid, 0);
    chk("fl_tag", bus.alloc_tag, 0);
    chk("fl_rdy0", bus.rd0_ready, 0);
    alloc(1, 'h300, 0, 0);
    #1;
    chk("post_fl_cnt", bus.count, 1);

    rst_n = 1'b0;
    #1;
    chk("arst_count", bus.count, 0);
    chk("arst_empty", bus.empty, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
